// File: rtl/mstream_pkg.sv
// Shared widths and state encoding for the MSTREAM pattern scheduler.
package mstream_pkg;

    localparam int unsigned CNT_W_DEF = 12;
    localparam int unsigned ROW_W_DEF = 16;
    localparam int unsigned PAT_W_DEF = 32;

    typedef logic [2:0] state_t;

    localparam state_t StIdle     = 3'd0;
    localparam state_t StWaitData = 3'd1;
    localparam state_t StStream   = 3'd2;
    localparam state_t StGap      = 3'd3;
    localparam state_t StLoad     = 3'd4;
    localparam state_t StDone     = 3'd5;

endpackage

// File: rtl/mstream_row_counter.sv
// Loadable down-counter with a terminal flag; shared by the row and gap phases.
module mstream_row_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_d, cnt_q;

    // Load has priority over decrement; the count never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mstream_scheduler.sv
// Read-side sequencer for the sensor pattern FIFO: streams num_pat patterns of
// rows_per_pat words each, separated by a programmable gap and a load strobe.
module mstream_scheduler
    import mstream_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ROW_W = ROW_W_DEF,
    parameter int unsigned PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig_i,
    input  logic             abort_i,
    input  logic [PAT_W-1:0] num_pat,
    input  logic [ROW_W-1:0] rows_per_pat,
    input  logic [ROW_W-1:0] gap_cycles,
    input  logic             fifo_empty,
    input  logic [CNT_W-1:0] fifo_rd_count,
    output logic             stream_en_o,
    output logic             pat_load_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [PAT_W-1:0] pat_idx_o,
    output logic             underflow_o
);

    localparam int unsigned CmpW = (CNT_W > ROW_W) ? CNT_W : ROW_W;

    state_t           state_d, state_q;
    logic [PAT_W-1:0] num_pat_d, num_pat_q;
    logic [ROW_W-1:0] rows_d, rows_q;
    logic [ROW_W-1:0] gap_d, gap_q;
    logic [PAT_W-1:0] pat_idx_d, pat_idx_q;
    logic             underflow_d, underflow_q;
    logic             stream_en_d, stream_en_q;
    logic             pat_load_d, pat_load_q;
    logic             busy_d, busy_q;
    logic             frame_done_d, frame_done_q;

    logic             cnt_load;
    logic [ROW_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_tc;
    logic             zero_trig;
    logic             data_ready;

    assign data_ready = (CmpW'(fifo_rd_count) >= CmpW'(rows_q));

    mstream_row_counter #(
        .W (ROW_W)
    ) u_row_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    // Next-state, config latch, pattern index and sticky underflow.
    always_comb begin
        state_d     = state_q;
        num_pat_d   = num_pat_q;
        rows_d      = rows_q;
        gap_d       = gap_q;
        pat_idx_d   = pat_idx_q;
        // Empty flag seen while reading is an underflow, whatever else happens.
        underflow_d = underflow_q | (stream_en_q & fifo_empty);
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_dec     = 1'b0;
        zero_trig   = 1'b0;

        if (abort_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (trig_i) begin
                        if ((num_pat != '0) && (rows_per_pat != '0)) begin
                            num_pat_d   = num_pat;
                            rows_d      = rows_per_pat;
                            gap_d       = gap_cycles;
                            pat_idx_d   = '0;
                            underflow_d = 1'b0;
                            state_d     = StWaitData;
                        end else begin
                            zero_trig = 1'b1;
                        end
                    end
                end
                StWaitData: begin
                    if (data_ready) begin
                        cnt_load = 1'b1;
                        cnt_val  = rows_q - 1'b1;
                        state_d  = StStream;
                    end
                end
                StStream: begin
                    if (cnt_tc) begin
                        if (gap_q != '0) begin
                            cnt_load = 1'b1;
                            cnt_val  = gap_q - 1'b1;
                            state_d  = StGap;
                        end else begin
                            state_d = StLoad;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_tc) begin
                        state_d = StLoad;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                StLoad: begin
                    pat_idx_d = pat_idx_q + 1'b1;
                    // Equality against num_pat-1 lets the full PAT_W range work.
                    if (pat_idx_q == (num_pat_q - 1'b1)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWaitData;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Moore outputs decoded from the next state so they register with it.
    always_comb begin
        stream_en_d  = (state_d == StStream);
        pat_load_d   = (state_d == StLoad);
        busy_d       = (state_d != StIdle);
        frame_done_d = (state_d == StDone) | zero_trig;
    end

    // State, config and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            num_pat_q    <= '0;
            rows_q       <= '0;
            gap_q        <= '0;
            pat_idx_q    <= '0;
            underflow_q  <= 1'b0;
            stream_en_q  <= 1'b0;
            pat_load_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_pat_q    <= num_pat_d;
            rows_q       <= rows_d;
            gap_q        <= gap_d;
            pat_idx_q    <= pat_idx_d;
            underflow_q  <= underflow_d;
            stream_en_q  <= stream_en_d;
            pat_load_q   <= pat_load_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign stream_en_o  = stream_en_q;
    assign pat_load_o   = pat_load_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign pat_idx_o    = pat_idx_q;
    assign underflow_o  = underflow_q;

endmodule

// File: doc/mstream_scheduler.md
Name: mstream_scheduler

Overview:
- Sequences the read side of the sensor pattern FIFO (the 256-bit-write / 32-bit-read mask FIFO feeding the ODDR MSTREAM outputs).
- On a frame trigger, streams Num_Pat patterns. Each pattern is rows_per_pat FIFO words read on consecutive cycles.
- Each pattern is followed by a programmable gap and a one-cycle pattern-load strobe to the sensor.
- Sits in the stream_clk domain and drives the FIFO rd_en / stream_en_i input directly.

Parameters:
- CNT_W, 12, width of the FIFO read-data-count input.
- ROW_W, 16, width of the row counter and gap counter.
- PAT_W, 32, width of the pattern counter and num_pat.

Ports:
- clk  in  1  stream clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- trig_i  in  1  frame start request. Accepted only in IDLE.
- abort_i  in  1  terminates the frame immediately.
- num_pat  in  PAT_W  patterns per frame. Sampled on trigger accept.
- rows_per_pat  in  ROW_W  FIFO words per pattern. Sampled on trigger accept.
- gap_cycles  in  ROW_W  idle cycles between the last row and the load strobe. Sampled on trigger accept.
- fifo_empty  in  1  pattern FIFO empty flag.
- fifo_rd_count  in  CNT_W  pattern FIFO read data count.
- stream_en_o  out  1  FIFO read enable, which is also the sensor stream enable.
- pat_load_o  out  1  one-cycle strobe after each complete pattern.
- busy_o  out  1  high in every state other than IDLE.
- frame_done_o  out  1  one-cycle pulse when a frame completes.
- pat_idx_o  out  PAT_W  index of the pattern currently being streamed.
- underflow_o  out  1  sticky error flag.

Behaviour:
- Reset: state=IDLE. All outputs are 0, counters are 0 and underflow_o is cleared.
- Interface rule: one clock (clk); reset is synchronous and active-high.
- All outputs are registered, Moore-style from the next state.
- IDLE:
  - trig_i=1 with num_pat!=0 and rows_per_pat!=0: latch the config, clear pat_idx and underflow_o, go to WAIT_DATA.
  - trig_i=1 with num_pat==0 or rows_per_pat==0: frame_done_o pulses the next cycle and the state stays IDLE.
- WAIT_DATA: when fifo_rd_count >= rows_per_pat_l, go to STREAM with row_cnt=0. Otherwise hold; there is no timeout.
- STREAM:
  - stream_en_o=1 for exactly rows_per_pat_l consecutive cycles.
  - row_cnt increments each cycle.
  - At row_cnt==rows_per_pat_l-1: go to GAP if gap_l!=0, else go to LOAD.
- GAP: stream_en_o=0 for exactly gap_l cycles, then go to LOAD.
- LOAD:
  - pat_load_o=1 for one cycle and pat_idx increments.
  - If pat_idx==num_pat_l-1 (before the increment), go to DONE; else go to WAIT_DATA.
- DONE: frame_done_o=1 for one cycle, then go to IDLE.
- Latency: trigger accepted at edge t gives WAIT_DATA at t+1. If data is ready, the first stream_en_o=1 is at t+2.
- WAIT_DATA to STREAM is always 1 cycle. There is therefore at least a 1-cycle stream_en_o gap between patterns, even with gap=0.
- Underflow: fifo_empty=1 in any cycle where stream_en_o=1 sets underflow_o. The sequence continues unchanged. underflow_o clears only on reset or on an accepted trigger.
- abort_i:
  - Highest priority after reset.
  - From any state, go to IDLE on the next edge. stream_en_o and pat_load_o drop that edge.
  - No frame_done_o pulse. pat_idx_o holds its last value and underflow_o is kept.
- trig_i while busy is ignored (no queueing). trig_i and abort_i together in IDLE: abort wins.
- Config input changes mid-frame have no effect until the next trigger.
- Counters use no wrap. num_pat up to 2^PAT_W-1 is supported by equality compare.

Decomposition:
- Package mstream_pkg holds:
  - the state enum: IDLE, WAIT_DATA, STREAM, GAP, LOAD, DONE;
  - the CNT_W, ROW_W and PAT_W defaults.
- One sub-module is natural: mstream_row_counter. It is a loadable down-counter with a terminal flag, reused for both the row count and the gap count.

Test Plan:
- num_pat=2, rows=4, gap=3, fifo_rd_count=100:
  - trigger at cycle 0 gives stream_en_o high in cycles 2–5, GAP in 6–8, pat_load_o at 9;
  - second pattern stream_en_o in 11–14, GAP 15–17, load at 18;
  - frame_done_o at 19, busy_o low from 20.
- rows=8, fifo_rd_count held at 5 for 20 cycles, then 8: stream_en_o stays 0 in WAIT_DATA and starts exactly 1 cycle after the count reaches 8.
- fifo_empty forced to 1 during the 3rd STREAM cycle: underflow_o goes to 1 and stays 1 after frame_done_o; the next trigger clears it.
- abort_i during pattern 1 STREAM:
  - stream_en_o is 0 the next cycle and the state is IDLE;
  - no frame_done_o, no pat_load_o;
  - a new trig_i is accepted.
- num_pat=0 trigger gives a single frame_done_o pulse and no stream_en_o. A trig_i mid-frame has no effect on cycle counts.
- Reset asserted mid-GAP: all outputs 0 the next cycle and underflow_o cleared.
